// File: rtl/nmea_pkg.sv
// Shared constants and FSM encoding for the NMEA stream arbiter.
package nmea_pkg;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FWD  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/nmea_stream_arbiter_if.sv
// Byte streams in, forwarded stream and status out; master = source/observer, slave = arbiter.
interface nmea_stream_arbiter_if;

    logic [7:0] in0_data;
    logic       in0_flag;
    logic [7:0] in1_data;
    logic       in1_flag;
    logic [7:0] out_data;
    logic       out_flag;
    logic       sel;
    logic       busy;
    logic       abort;
    logic [7:0] drop_cnt0;
    logic [7:0] drop_cnt1;

    modport master (
        output in0_data, in0_flag, in1_data, in1_flag,
        input  out_data, out_flag, sel, busy, abort, drop_cnt0, drop_cnt1
    );

    modport slave (
        input  in0_data, in0_flag, in1_data, in1_flag,
        output out_data, out_flag, sel, busy, abort, drop_cnt0, drop_cnt1
    );

endinterface

// File: rtl/nmea_drop_counter.sv
// 8-bit saturating event counter for bytes dropped on a non-granted stream.
module nmea_drop_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    output logic [7:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/nmea_stream_arbiter.sv
// Two-stream NMEA sentence arbiter: grants on '$', forwards until LF or length overflow.
// Optional inter-byte stall timeout in FWD is enabled by defining NMEA_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for '$' on either stream; other bytes ignored
// FWD     | forwarding granted stream, dropping and counting the other
module nmea_stream_arbiter
    import nmea_pkg::*;
#(
    parameter int MAX_LEN        = 82,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    nmea_stream_arbiter_if.slave bus
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    arb_state_t       state;
    logic             sel_q;
    logic             prev_win;
    logic [LEN_W-1:0] len_cnt;
    logic [7:0]       out_data_q;
    logic             out_flag_q;
    logic             abort_q;

    logic             dollar0;
    logic             dollar1;
    logic             g_flag;
    logic [7:0]       g_data;
    logic             drop_inc0;
    logic             drop_inc1;

`ifdef NMEA_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);
    logic [TMR_W-1:0] tmr;
`endif

    assign dollar0   = bus.in0_flag && (bus.in0_data == ASCII_DOLLAR);
    assign dollar1   = bus.in1_flag && (bus.in1_data == ASCII_DOLLAR);
    assign g_flag    = sel_q ? bus.in1_flag : bus.in0_flag;
    assign g_data    = sel_q ? bus.in1_data : bus.in0_data;
    assign drop_inc0 = (state == ST_FWD) &&  sel_q && bus.in0_flag;
    assign drop_inc1 = (state == ST_FWD) && !sel_q && bus.in1_flag;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            sel_q      <= 1'b0;
            prev_win   <= 1'b1;
            len_cnt    <= '0;
            out_data_q <= '0;
            out_flag_q <= 1'b0;
            abort_q    <= 1'b0;
`ifdef NMEA_ARB_TIMEOUT_EN
            tmr        <= TMR_LOAD;
`endif
        end else begin
            out_flag_q <= 1'b0;
            abort_q    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dollar0 || dollar1) begin
                        // On a tie the previous winner yields
                        sel_q      <= (dollar0 && dollar1) ? ~prev_win : dollar1;
                        state      <= ST_FWD;
                        out_data_q <= ASCII_DOLLAR;
                        out_flag_q <= 1'b1;
                        len_cnt    <= LEN_ONE;
`ifdef NMEA_ARB_TIMEOUT_EN
                        tmr        <= TMR_LOAD;
`endif
                    end
                end
                ST_FWD: begin
                    if (g_flag) begin
`ifdef NMEA_ARB_TIMEOUT_EN
                        tmr <= TMR_LOAD;
`endif
                        if (g_data == ASCII_DOLLAR) begin
                            out_data_q <= g_data;
                            out_flag_q <= 1'b1;
                            len_cnt    <= LEN_ONE;
                        end else if (len_cnt == LEN_MAX) begin
                            abort_q <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            out_data_q <= g_data;
                            out_flag_q <= 1'b1;
                            len_cnt    <= len_cnt + LEN_ONE;
                            if (g_data == ASCII_LF) begin
                                state    <= ST_IDLE;
                                prev_win <= sel_q;
                            end
                        end
                    end
`ifdef NMEA_ARB_TIMEOUT_EN
                    else if (tmr == TMR_W'(1)) begin
                        abort_q <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
`endif
                end
            endcase
        end
    end

    assign bus.out_data = out_data_q;
    assign bus.out_flag = out_flag_q;
    assign bus.sel      = sel_q;
    assign bus.busy     = (state == ST_FWD);
    assign bus.abort    = abort_q;

    nmea_drop_counter u_drop0 (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .inc   (drop_inc0),
        .cnt   (bus.drop_cnt0)
    );

    nmea_drop_counter u_drop1 (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .inc   (drop_inc1),
        .cnt   (bus.drop_cnt1)
    );

endmodule

// File: doc/nmea_stream_arbiter.md
NMEA_STREAM_ARBITER -- requirements
Module: nmea_stream_arbiter

Interface
REQ-001 SHALL have parameter MAX_LEN, default 82: maximum sentence length in bytes, '$' through LF inclusive.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000: inter-byte stall limit in FWD (1 s at 50 MHz).
REQ-003 SHALL have port sys_clk, input, 1: the single clock, 50 MHz.
REQ-004 SHALL have port sys_rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in0_data, input, 8: byte from UART receiver 0.
REQ-006 SHALL have port in0_flag, input, 1: single-cycle valid for in0_data.
REQ-007 SHALL have port in1_data, input, 8: byte from UART receiver 1.
REQ-008 SHALL have port in1_flag, input, 1: single-cycle valid for in1_data.
REQ-009 SHALL have port out_data, output, 8: forwarded byte to the downstream sentence decoder.
REQ-010 SHALL have port out_flag, output, 1: single-cycle valid for out_data.
REQ-011 SHALL have port sel, output, 1: stream currently or last granted.
REQ-012 SHALL have port busy, output, 1: high while in FWD.
REQ-013 SHALL have port abort, output, 1: one-cycle pulse when a sentence is truncated.
REQ-014 SHALL have ports drop_cnt0 and drop_cnt1, output, 8 each: saturating count of dropped bytes per stream.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and FWD.
REQ-016 In IDLE, a flagged byte equal to 0x24 ('$') SHALL grant its stream, move to FWD and be forwarded; all other IDLE bytes are ignored and not counted.
REQ-017 If both streams present '$' in the same IDLE cycle, the stream that is not the previous winner SHALL be granted; after reset the previous winner is stream 1, so stream 0 wins the first tie.
REQ-018 Forwarded bytes SHALL appear on out_data/out_flag exactly 1 cycle after the input flag; out_flag SHALL never be high two cycles in a row unless the input was.
REQ-019 In FWD, a granted byte equal to 0x0A (LF) SHALL be forwarded, return the FSM to IDLE and record sel as the previous winner.
REQ-020 In FWD, a granted '$' SHALL be forwarded and restart the length count without leaving FWD.
REQ-021 In FWD, every flagged byte on the non-granted stream SHALL be dropped and SHALL increment that stream's drop counter, saturating at 255; this includes a '$' arriving in the same cycle the granted stream delivers LF.
REQ-022 A length counter SHALL count forwarded bytes since the last '$'; a granted byte that would make the count exceed MAX_LEN SHALL NOT be forwarded, SHALL pulse abort on the next cycle, and SHALL return the FSM to IDLE.
REQ-023 sel SHALL change only on a grant and SHALL hold its value in IDLE.

Reset
REQ-024 When reset is asserted, the block SHALL set: state=IDLE, out_data=0, out_flag=0, sel=0, busy=0, abort=0, drop counters=0, length counter=0, previous winner=1.
REQ-025 Reset asserted mid-sentence SHALL discard the sentence silently, with no abort pulse.

Configuration
REQ-026 With macro NMEA_ARB_TIMEOUT_EN defined, an idle-cycle counter in FWD SHALL clear on each granted byte; on reaching TIMEOUT_CYCLES it SHALL pulse abort and return the FSM to IDLE.
REQ-027 Without NMEA_ARB_TIMEOUT_EN, no timeout counter SHALL exist, and FWD SHALL be left only by LF, length overflow or reset.

Structure
REQ-028 Shared package nmea_pkg SHALL hold ASCII_DOLLAR (0x24), ASCII_LF (0x0A), ASCII_STAR (0x2A), ASCII_COMMA (0x2C) and the FSM state encoding.
REQ-029 A sub-module nmea_drop_counter (8-bit saturating increment) SHALL be instantiated once per stream.

Verification
REQ-030 Stream 0 sends "$GPRMC,...\r\n" (70 B) while stream 1 is idle -> 70 out_flag pulses, each 1 cycle later with identical data; busy falls after LF.
REQ-031 Both streams send '$' in the same cycle, twice in succession -> grant order is 0 then 1; the loser's bytes increment its drop counter once per byte.
REQ-032 Stream 1 sends 83 bytes with no LF -> 82 bytes forwarded, abort pulses once, FSM returns to IDLE, and the next '$' is granted.
REQ-033 Stream 0 is granted and 300 stream-1 bytes arrive -> drop_cnt1 = 255 and holds.
REQ-034 With NMEA_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, stream 0 sends "$GP" then stalls -> abort after 100 idle cycles; without the macro -> busy stays high.
REQ-035 sys_rst_n is pulsed low mid-sentence -> all outputs 0, no abort, and the next '$' on stream 0 is granted.
